// File: rtl/hd44780_pkg.sv
// Shared constants for the HD44780 4-bit bus driver: symbol select codes,
// LCD byte values, default bus timing and the transfer FSM encoding.
package hd44780_pkg;

    localparam int T_AS_DEF  = 6;
    localparam int T_PW_DEF  = 48;
    localparam int T_H_DEF   = 4;
    localparam int T_GAP_DEF = 100;

    // Character-mode selects use only sel[1:0].
    localparam logic [1:0] SEL_DIGIT = 2'b00;
    localparam logic [1:0] SEL_SEP   = 2'b01;
    localparam logic [1:0] SEL_M     = 2'b10;
    localparam logic [1:0] SEL_AP    = 2'b11;

    localparam logic [2:0] SEL_DDRAM = 3'b000;
    localparam logic [2:0] SEL_INIT3 = 3'b100;
    localparam logic [2:0] SEL_INIT2 = 3'b101;
    localparam logic [2:0] SEL_FUNC  = 3'b110;
    localparam logic [2:0] SEL_DISP  = 3'b111;

    localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
    // Init nibbles travel in the upper half; the lower half is never sent.
    localparam logic [7:0] LCD_INIT3     = 8'h30;
    localparam logic [7:0] LCD_INIT2     = 8'h20;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_M     = 8'h4D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AS_H,
        ST_PW_H,
        ST_H_H,
        ST_GAP,
        ST_AS_L,
        ST_PW_L,
        ST_H_L
    } lcd_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hd44780_char_map.sv
// Maps a sequencer symbol {data, sel, val} to the HD44780 byte it stands for,
// flagging the init symbols that are sent as a single upper nibble.
module hd44780_char_map
    import hd44780_pkg::*;
(
    input  logic       data,
    input  logic [2:0] sel,
    input  logic [3:0] val,
    output logic [7:0] lcd_byte,
    output logic       nibble_only
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        lcd_byte    = LCD_CLEAR;
        nibble_only = 1'b0;
        if (data) begin
            unique case (sel[1:0])
                SEL_DIGIT: lcd_byte = (val <= 4'd9) ? (CH_ZERO + {4'h0, val}) : CH_QMARK;
                SEL_SEP:   lcd_byte = val[0] ? CH_SPACE : CH_COLON;
                SEL_AP:    lcd_byte = val[0] ? CH_P : CH_A;
                SEL_M:     lcd_byte = CH_M;
                default:   lcd_byte = CH_M;
            endcase
        end else begin
            case (sel)
                SEL_INIT3: begin lcd_byte = LCD_INIT3; nibble_only = 1'b1; end
                SEL_INIT2: begin lcd_byte = LCD_INIT2; nibble_only = 1'b1; end
                SEL_FUNC:  lcd_byte = LCD_FUNC_4BIT;
                SEL_DISP:  lcd_byte = LCD_DISP_ON;
                SEL_DDRAM: lcd_byte = LCD_SET_DDRAM | {4'h0, val};
                default:   lcd_byte = LCD_CLEAR;
            endcase
        end
    end

endmodule

// File: rtl/hd44780_lcd_driver.sv
// HD44780 4-bit pin driver: turns each rising edge of the sequencer trigger
// into one timed nibble or byte write on RS/E/DB7..DB4.
module hd44780_lcd_driver
    import hd44780_pkg::*;
#(
    parameter int T_AS  = T_AS_DEF,
    parameter int T_PW  = T_PW_DEF,
    parameter int T_H   = T_H_DEF,
    parameter int T_GAP = T_GAP_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_e_trigger,
    input  logic       i_data,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_val,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [3:0] o_lcd_db,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam int CNT_W = $clog2(max4(T_AS, T_PW, T_H, T_GAP)) + 1;

    lcd_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic             trig_q, trig_rise, accept;
    logic             cap_data;
    logic [2:0]       cap_sel;
    logic [3:0]       cap_val;
    logic [7:0]       map_byte;
    logic             map_nibble_only;
    logic             rs_hold, rs_cur, e_cur;
    logic [3:0]       db_hold, db_cur;
    logic             overrun_q;

    assign trig_rise = i_e_trigger & ~trig_q;
    assign accept    = trig_rise && (state == ST_IDLE);

    hd44780_char_map u_char_map (
        .data        (cap_data),
        .sel         (cap_sel),
        .val         (cap_val),
        .lcd_byte    (map_byte),
        .nibble_only (map_nibble_only)
    );

    // Phase length of the state about to be entered, minus one.
    always_comb begin
        cnt_load = '0;
        case (state_next)
            ST_AS_H, ST_AS_L: cnt_load = CNT_W'(T_AS - 1);
            ST_PW_H, ST_PW_L: cnt_load = CNT_W'(T_PW - 1);
            ST_H_H,  ST_H_L:  cnt_load = CNT_W'(T_H - 1);
            ST_GAP:           cnt_load = CNT_W'(T_GAP - 1);
            default:          cnt_load = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next == ST_IDLE)
                cnt <= '0;
            else if (state_next != state)
                cnt <= cnt_load;
            else
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (trig_rise)  state_next = ST_AS_H;
            ST_AS_H: if (cnt == '0)  state_next = ST_PW_H;
            ST_PW_H: if (cnt == '0)  state_next = ST_H_H;
            ST_H_H:  if (cnt == '0)  state_next = map_nibble_only ? ST_IDLE : ST_GAP;
            ST_GAP:  if (cnt == '0)  state_next = ST_AS_L;
            ST_AS_L: if (cnt == '0)  state_next = ST_PW_L;
            ST_PW_L: if (cnt == '0)  state_next = ST_H_L;
            ST_H_L:  if (cnt == '0)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rs_cur = rs_hold;
        db_cur = db_hold;
        e_cur  = 1'b0;
        case (state)
            ST_AS_H, ST_H_H, ST_GAP: begin
                rs_cur = cap_data;
                db_cur = map_byte[7:4];
            end
            ST_PW_H: begin
                rs_cur = cap_data;
                db_cur = map_byte[7:4];
                e_cur  = 1'b1;
            end
            ST_AS_L, ST_H_L: begin
                rs_cur = cap_data;
                db_cur = map_byte[3:0];
            end
            ST_PW_L: begin
                rs_cur = cap_data;
                db_cur = map_byte[3:0];
                e_cur  = 1'b1;
            end
            default: ;
        endcase
    end

    // Symbol capture, edge detect, overrun flag and the idle-time bus hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            trig_q    <= 1'b0;
            cap_data  <= 1'b0;
            cap_sel   <= '0;
            cap_val   <= '0;
            overrun_q <= 1'b0;
            rs_hold   <= 1'b0;
            db_hold   <= '0;
        end else begin
            trig_q <= i_e_trigger;
            if (accept) begin
                cap_data <= i_data;
                cap_sel  <= i_sel;
                cap_val  <= i_val;
            end
            if (trig_rise && state != ST_IDLE)
                overrun_q <= 1'b1;
            if (state != ST_IDLE) begin
                rs_hold <= rs_cur;
                db_hold <= db_cur;
            end
        end
    end

    assign o_lcd_rs  = rs_cur;
    assign o_lcd_rw  = 1'b0;
    assign o_lcd_e   = e_cur;
    assign o_lcd_db  = db_cur;
    assign o_busy    = (state != ST_IDLE);
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_hd44780_lcd_driver.sv
// Directed bench for hd44780_lcd_driver: bus timing, symbol mapping,
// trigger edge handling, overrun and mid-transfer reset.
module tb_hd44780_lcd_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig;
    logic       data;
    logic [2:0] sel;
    logic [3:0] val;
    logic       lcd_rs, lcd_rw, lcd_e, busy, overrun;
    logic [3:0] lcd_db;

    int tests = 0;
    int fails = 0;

    // Results of the most recent xfer() call.
    int         r_busy, r_pulses, r_ehi, r_fall1, r_fall2;
    logic [3:0] r_nib1, r_nib2, r_first_db;
    logic       r_first_e, r_rs, r_rw_bad, r_unstable;

    logic [7:0] stream_sym [12] = '{8'h00, 8'h81, 8'h82, 8'h90, 8'h83, 8'h84,
                                    8'h90, 8'h85, 8'h86, 8'h91, 8'hB1, 8'hA0};
    logic [7:0] stream_exp [12] = '{8'h80, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34,
                                    8'h3A, 8'h35, 8'h36, 8'h20, 8'h50, 8'h4D};

    always #5 clk = ~clk;

    hd44780_lcd_driver dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_e_trigger (trig),
        .i_data      (data),
        .i_sel       (sel),
        .i_val       (val),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_e     (lcd_e),
        .o_lcd_db    (lcd_db),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Raise the trigger for one symbol and record the bus activity sample by
    // sample (#1 after each edge) until busy drops; k=0 is the cycle after
    // the accepting edge.
    task automatic xfer(input logic d, input logic [2:0] s, input logic [3:0] v);
        int   k;
        logic e_prev;
        logic [3:0] db_at_rise;
        @(negedge clk);
        data = d; sel = s; val = v; trig = 1'b1;
        @(posedge clk); #1;
        r_pulses = 0; r_ehi = 0; r_fall1 = -1; r_fall2 = -1;
        r_nib1 = '0; r_nib2 = '0; r_rw_bad = 1'b0; r_unstable = 1'b0;
        r_first_db = lcd_db; r_first_e = lcd_e; r_rs = lcd_rs;
        e_prev = 1'b0; db_at_rise = '0; k = 0;
        while (busy && k < 400) begin
            if (lcd_rw !== 1'b0) r_rw_bad = 1'b1;
            if (lcd_rs !== r_rs) r_unstable = 1'b1;
            if (lcd_e) begin
                r_ehi++;
                if (!e_prev) begin
                    r_pulses++;
                    db_at_rise = lcd_db;
                    if (r_pulses == 1) r_nib1 = lcd_db;
                    else               r_nib2 = lcd_db;
                end else if (lcd_db !== db_at_rise) begin
                    r_unstable = 1'b1;
                end
            end else if (e_prev) begin
                if (r_pulses == 1) r_fall1 = k;
                else               r_fall2 = k;
            end
            e_prev = lcd_e;
            k++;
            @(posedge clk); #1;
        end
        r_busy = k;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        int   starts;
        int   k;
        logic prev_busy;

        reset = 1'b1; trig = 1'b0; data = 1'b0; sel = '0; val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {lcd_rs, lcd_rw, lcd_e, lcd_db, busy, overrun}, 9'h000);

        // Trigger rising while reset is held must not start a transfer.
        trig = 1'b1;
        @(posedge clk); #1;
        check("reset_wins_busy", busy, 1'b0);
        @(negedge clk);
        trig = 1'b0; reset = 1'b0;
        @(negedge clk);

        // Init nibble 0x3: one E pulse, busy 58 cycles.
        xfer(1'b0, 3'b100, 4'h0);
        check("init3_busy",   r_busy,     58);
        check("init3_pulses", r_pulses,   1);
        check("init3_e_high", r_ehi,      48);
        check("init3_fall",   r_fall1,    54);
        check("init3_db",     r_nib1,     4'h3);
        check("init3_rs",     r_rs,       1'b0);
        check("init3_first",  {r_first_e, r_first_db}, {1'b0, 4'h3});

        // Digit 7 -> 0x37: two pulses, falls 158 apart, busy 216.
        xfer(1'b1, 3'b000, 4'h7);
        check("digit_busy",    r_busy,            216);
        check("digit_pulses",  r_pulses,          2);
        check("digit_e_high",  r_ehi,             96);
        check("digit_fall1",   r_fall1,           54);
        check("digit_fall_gap", r_fall2 - r_fall1, 158);
        check("digit_byte",    {r_nib1, r_nib2},  8'h37);
        check("digit_rs",      r_rs,              1'b1);
        check("digit_first",   {r_first_e, r_first_db}, {1'b0, 4'h3});
        check("digit_stable",  {r_unstable, r_rw_bad}, 2'b00);
        check("idle_hold",     {lcd_rs, lcd_e, lcd_db}, {1'b1, 1'b0, 4'h7});

        xfer(1'b1, 3'b001, 4'h0);
        check("char_colon", {r_nib1, r_nib2}, 8'h3A);
        xfer(1'b1, 3'b011, 4'h1);
        check("char_p", {r_nib1, r_nib2}, 8'h50);
        xfer(1'b1, 3'b010, 4'h0);
        check("char_m", {r_nib1, r_nib2}, 8'h4D);
        xfer(1'b1, 3'b000, 4'hC);
        check("char_qmark", {r_nib1, r_nib2}, 8'h3F);
        xfer(1'b1, 3'b111, 4'h0);
        check("char_a_sel2_ignored", {r_nib1, r_nib2}, 8'h41);

        // Trigger held for 2000 cycles: exactly one transfer, no overrun.
        @(negedge clk);
        data = 1'b0; sel = 3'b111; val = '0; trig = 1'b1;
        starts = 0; prev_busy = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (busy && !prev_busy) starts++;
            prev_busy = busy;
        end
        check("held_one_transfer", starts, 1);
        check("held_no_overrun", overrun, 1'b0);
        @(negedge clk);
        trig = 1'b0;

        // Second rising edge 50 cycles into a transfer: dropped, overrun sticks.
        @(negedge clk);
        data = 1'b1; sel = 3'b000; val = 4'h2; trig = 1'b1;
        @(posedge clk); #1;
        check("ovr_busy_start", busy, 1'b1);
        repeat (48) @(posedge clk);
        @(negedge clk); trig = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(posedge clk); #1;
        check("ovr_flag", overrun, 1'b1);
        k = 0;
        while (busy && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("ovr_busy_end", busy, 1'b0);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) starts++;
        end
        check("ovr_no_retrigger", starts, 0);
        check("ovr_sticky", overrun, 1'b1);
        @(negedge clk); trig = 1'b0;

        // Reset during PW_H abandons the transfer and clears overrun.
        @(negedge clk);
        data = 1'b0; sel = 3'b110; val = '0; trig = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); trig = 1'b0;
        k = 0;
        while (!lcd_e && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_reached_pw", lcd_e, 1'b1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_e",       lcd_e,   1'b0);
        check("rst_mid_busy",    busy,    1'b0);
        check("rst_mid_overrun", overrun, 1'b0);
        check("rst_mid_bus",     {lcd_rs, lcd_db}, 5'h00);
        @(negedge clk); reset = 1'b0;
        xfer(1'b0, 3'b110, 4'h0);
        check("post_rst_busy", r_busy, 216);
        check("post_rst_byte", {r_nib1, r_nib2}, 8'h28);

        // Sequencer-style stream: DDRAM address then "12:34:56 PM".
        for (int i = 0; i < 12; i++) begin
            xfer(stream_sym[i][7], stream_sym[i][6:4], stream_sym[i][3:0]);
            check($sformatf("stream_byte_%0d", i), {r_nib1, r_nib2}, stream_exp[i]);
            check($sformatf("stream_bus_%0d", i), {r_pulses[3:0], r_rw_bad, r_rs},
                  {4'd2, 1'b0, stream_sym[i][7]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
